// File: rtl/lms_orca_oc_mem_loader_if.sv
// Avalon-MM bus to the ORCA on-chip memory plus the host byte stream, as seen by the loader.
// The master modport is the loader side; the slave modport is the memory and host side.
interface lms_orca_oc_mem_loader_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata,
    input  s_data, s_valid,
    output s_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata,
    output s_data, s_valid,
    input  s_ready
  );
endinterface

// File: rtl/lms_orca_oc_mem_loader.sv
// Packs a host byte stream into 32-bit writes to the ORCA on-chip memory and checksums them.
// Define ORCA_LOADER_VERIFY_EN to build the VERIFY mode (read a word range back and checksum it).
module lms_orca_oc_mem_loader #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 14
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_start,
  input  logic                     cmd_mode,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [LEN_W-1:0]         cmd_words,
  input  logic                     cmd_abort,
  lms_orca_oc_mem_loader_if.master bus,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              checksum
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_WRITE    = 3'd2,
`ifdef ORCA_LOADER_VERIFY_EN
    ST_RD_ISSUE = 3'd3,
    ST_RD_DRAIN = 3'd4,
`endif
    ST_FINISH   = 3'd5
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [LEN_W-1:0]  remain_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       shift_r;
  logic              rd_pend_r;
  logic              busy_r;
  logic              done_r;
  logic [31:0]       checksum_r;
  logic              s_ready_r;
  logic              cs_r;
  logic              wr_r;
  logic [3:0]        be_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;

  // Word pointer advance; the memory address space wraps at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return p + ADDR_W'(1);
  endfunction

`ifndef ORCA_LOADER_VERIFY_EN
  logic unused_s;
  assign unused_s = ^{cmd_mode, bus.avm_readdata};
`endif

  // Command sequencer: FSM state, bus strobes and status flags, all registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {ADDR_W{1'b0}};
      remain_r   <= {LEN_W{1'b0}};
      byte_cnt_r <= 2'd0;
      shift_r    <= 24'h00_0000;
      rd_pend_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      checksum_r <= 32'h0000_0000;
      s_ready_r  <= 1'b0;
      cs_r       <= 1'b0;
      wr_r       <= 1'b0;
      be_r       <= 4'h0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= 32'h0000_0000;
    end else begin
      done_r <= 1'b0;
      if (cmd_abort && (state_r != ST_IDLE)) begin
        // A write already on the bus completes and still counts toward the checksum.
        if (state_r == ST_WRITE) begin
          checksum_r <= checksum_r + wdata_r;
        end else begin
          checksum_r <= checksum_r;
        end
        state_r    <= ST_IDLE;
        busy_r     <= 1'b0;
        s_ready_r  <= 1'b0;
        cs_r       <= 1'b0;
        wr_r       <= 1'b0;
        be_r       <= 4'h0;
        rd_pend_r  <= 1'b0;
        byte_cnt_r <= 2'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (cmd_start && !cmd_abort) begin
              ptr_r      <= cmd_addr;
              remain_r   <= cmd_words;
              checksum_r <= 32'h0000_0000;
              busy_r     <= 1'b1;
              byte_cnt_r <= 2'd0;
              rd_pend_r  <= 1'b0;
              if (cmd_words == LEN_W'(0)) begin
                state_r <= ST_FINISH;
              end
`ifdef ORCA_LOADER_VERIFY_EN
              else if (cmd_mode) begin
                state_r <= ST_RD_ISSUE;
                cs_r    <= 1'b1;
                wr_r    <= 1'b0;
                be_r    <= 4'hF;
                addr_r  <= cmd_addr;
              end
`endif
              else begin
                state_r   <= ST_COLLECT;
                s_ready_r <= 1'b1;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end

          ST_COLLECT: begin
            if (bus.s_valid) begin
              if (byte_cnt_r == 2'd3) begin
                wdata_r    <= {bus.s_data, shift_r};
                addr_r     <= ptr_r;
                cs_r       <= 1'b1;
                wr_r       <= 1'b1;
                be_r       <= 4'hF;
                s_ready_r  <= 1'b0;
                byte_cnt_r <= 2'd0;
                state_r    <= ST_WRITE;
              end else begin
                shift_r    <= {bus.s_data, shift_r[23:8]};
                byte_cnt_r <= byte_cnt_r + 2'd1;
              end
            end else begin
              state_r <= ST_COLLECT;
            end
          end

          ST_WRITE: begin
            cs_r       <= 1'b0;
            wr_r       <= 1'b0;
            be_r       <= 4'h0;
            checksum_r <= checksum_r + wdata_r;
            ptr_r      <= next_ptr(ptr_r);
            remain_r   <= remain_r - LEN_W'(1);
            if (remain_r == LEN_W'(1)) begin
              state_r <= ST_FINISH;
            end else begin
              state_r   <= ST_COLLECT;
              s_ready_r <= 1'b1;
            end
          end

`ifdef ORCA_LOADER_VERIFY_EN
          ST_RD_ISSUE: begin
            // Data of the previous cycle's read is on avm_readdata now.
            if (rd_pend_r) begin
              checksum_r <= checksum_r + bus.avm_readdata;
            end else begin
              checksum_r <= checksum_r;
            end
            rd_pend_r <= 1'b1;
            ptr_r     <= next_ptr(ptr_r);
            remain_r  <= remain_r - LEN_W'(1);
            if (remain_r == LEN_W'(1)) begin
              cs_r    <= 1'b0;
              be_r    <= 4'h0;
              state_r <= ST_RD_DRAIN;
            end else begin
              addr_r <= next_ptr(ptr_r);
            end
          end

          ST_RD_DRAIN: begin
            checksum_r <= checksum_r + bus.avm_readdata;
            rd_pend_r  <= 1'b0;
            state_r    <= ST_FINISH;
          end
`endif

          ST_FINISH: begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end

          default: begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            s_ready_r <= 1'b0;
            cs_r      <= 1'b0;
            wr_r      <= 1'b0;
            be_r      <= 4'h0;
          end
        endcase
      end
    end
  end

  assign bus.avm_address    = addr_r;
  assign bus.avm_chipselect = cs_r;
  assign bus.avm_write      = wr_r;
  assign bus.avm_byteenable = be_r;
  assign bus.avm_writedata  = wdata_r;
  assign bus.s_ready        = s_ready_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign checksum           = checksum_r;

endmodule

// File: tb/tb_lms_orca_oc_mem_loader.sv
// Randomized self-checking bench for lms_orca_oc_mem_loader against a word-level reference model.
// Runs the VERIFY scenarios only when ORCA_LOADER_VERIFY_EN is defined.
module tb_lms_orca_oc_mem_loader;
  localparam int ADDR_W = 13;
  localparam int LEN_W  = 14;
`ifdef ORCA_LOADER_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_start = 1'b0;
  logic              cmd_mode = 1'b0;
  logic              cmd_abort = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_words = '0;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;

  lms_orca_oc_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  lms_orca_oc_mem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_words(cmd_words), .cmd_abort(cmd_abort),
    .bus(bus), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: 1-cycle read latency, garbage when no read was issued.
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (bus.avm_chipselect && !bus.avm_write) bus.avm_readdata <= mem[bus.avm_address];
    else bus.avm_readdata <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [3:0]        be;
    int                c;
  } bus_ev_t;

  bus_ev_t wq[$];
  bus_ev_t rq[$];
  int cyc = 0, done_cnt = 0, done_cyc = -1, cs_cnt = 0, sr_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus/status monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.avm_chipselect) begin
        cs_cnt <= cs_cnt + 1;
        if (bus.avm_write) begin
          wq.push_back('{bus.avm_address, bus.avm_writedata, bus.avm_byteenable, cyc});
          if (bus.s_ready) sr_viol <= sr_viol + 1;
        end else begin
          rq.push_back('{bus.avm_address, 32'h0, bus.avm_byteenable, cyc});
        end
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  logic [7:0] src[$];
  int start_cyc = 0;

  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a, input int i);
    return a + ADDR_W'(i);
  endfunction

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [ADDR_W-1:0] a, input int n, input logic m);
    cmd_addr  = a;
    cmd_words = LEN_W'(n);
    cmd_mode  = m;
    cmd_start = 1'b1;
    start_cyc = cyc;
    clk_step();
    cmd_start = 1'b0;
  endtask

  // gap: 0 gapless, 1 toggle every cycle, 2 random; abort_at < 0 means no abort.
  task automatic run_load(input logic [ADDR_W-1:0] a, input int n, input int gap,
                          input logic m, input int abort_at, input bit poke);
    int w0, d0, idx, nb, nexp, nact;
    bit aborted, acc;
    logic [31:0] sum, word;
    w0 = wq.size(); d0 = done_cnt; nb = n * 4; idx = 0; aborted = 1'b0; sum = 32'h0;
    start_cmd(a, n, m);
    for (int t = 0; t < 4000 && idx < nb && !aborted; t++) begin
      if (abort_at >= 0 && idx == abort_at) begin
        bus.s_valid = 1'b0;
        cmd_abort   = 1'b1;
        clk_step();
        cmd_abort   = 1'b0;
        aborted     = 1'b1;
        @(negedge clk);
        chk("abort_busy", {63'h0, busy}, 64'h0);
      end else begin
        case (gap)
          0:       bus.s_valid = 1'b1;
          1:       bus.s_valid = t[0];
          default: bus.s_valid = 1'($urandom_range(0, 1));
        endcase
        bus.s_data = src[idx];
        cmd_start  = poke && (idx == 5);
        cmd_addr   = a ^ 13'h00AA;
        @(negedge clk);
        acc = bus.s_valid && bus.s_ready;
        clk_step();
        cmd_start = 1'b0;
        if (acc) idx++;
      end
    end
    bus.s_valid = 1'b0;
    for (int t = 0; t < 20 && done_cnt == d0; t++) clk_step();
    repeat (3) clk_step();
    nexp = aborted ? abort_at / 4 : n;
    nact = wq.size() - w0;
    chk("ld_wr_count", 64'(nact), 64'(nexp));
    for (int i = 0; i < nexp && i < nact; i++) begin
      word = {src[4*i+3], src[4*i+2], src[4*i+1], src[4*i]};
      sum += word;
      chk("ld_addr", 64'(wq[w0+i].a), 64'(wrap(a, i)));
      chk("ld_data", 64'(wq[w0+i].d), 64'(word));
      chk("ld_be", 64'(wq[w0+i].be), 64'h0F);
    end
    chk("ld_done_cnt", 64'(done_cnt - d0), aborted ? 64'h0 : 64'h1);
    chk("ld_checksum", 64'(checksum), 64'(sum));
    chk("ld_idle_busy", {63'h0, busy}, 64'h0);
  endtask

  task automatic run_zero(input logic m);
    int c0, d0;
    c0 = cs_cnt; d0 = done_cnt;
    start_cmd(13'h0123, 0, m);
    repeat (4) clk_step();
    chk("zero_done_cnt", 64'(done_cnt - d0), 64'h1);
    chk("zero_done_lat", 64'(done_cyc - start_cyc), 64'h2);
    chk("zero_no_cs", 64'(cs_cnt - c0), 64'h0);
    chk("zero_checksum", 64'(checksum), 64'h0);
  endtask

`ifdef ORCA_LOADER_VERIFY_EN
  task automatic run_verify(input logic [ADDR_W-1:0] a, input int n);
    int r0, d0, nact, lat;
    logic [31:0] sum;
    r0 = rq.size(); d0 = done_cnt; sum = 32'h0;
    for (int i = 0; i < n; i++) sum += mem[wrap(a, i)];
    start_cmd(a, n, 1'b1);
    for (int t = 0; t < n + 20 && done_cnt == d0; t++) clk_step();
    repeat (2) clk_step();
    nact = rq.size() - r0;
    chk("vf_rd_count", 64'(nact), 64'(n));
    for (int i = 0; i < n && i < nact; i++) begin
      chk("vf_addr", 64'(rq[r0+i].a), 64'(wrap(a, i)));
      chk("vf_b2b", 64'(rq[r0+i].c - rq[r0].c), 64'(i));
    end
    chk("vf_done_cnt", 64'(done_cnt - d0), 64'h1);
    chk("vf_checksum", 64'(checksum), 64'(sum));
    if (nact > 0) begin
      lat = done_cyc - rq[r0].c;
      chk("vf_done_lat", {63'h0, (lat == n + 1) || (lat == n + 2)}, 64'h1);
    end else begin
      chk("vf_no_reads", 64'(nact), 64'(n));
    end
  endtask
`endif

  task automatic run_reset_mid(input logic m);
    bit seen;
    seen = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    start_cmd(13'h0040, 8, m);
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      seen = bus.avm_chipselect;
    end
    chk("rst_cs_seen", {63'h0, seen}, 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_bus", 64'({bus.avm_chipselect, bus.avm_write, bus.avm_byteenable, bus.avm_address}), 64'h0);
    chk("rst_wdata", 64'(bus.avm_writedata), 64'h0);
    chk("rst_ctl", 64'({bus.s_ready, busy, done, checksum}), 64'h0);
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clk_step();
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", 64'({busy, done, checksum}), 64'h0);
    chk("reset_bus", 64'({bus.avm_chipselect, bus.avm_write, bus.avm_byteenable, bus.s_ready}), 64'h0);
    reset_n = 1'b1;
    clk_step();

    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(8'(i + 1));
    run_load(13'h0010, 2, 0, 1'b0, -1, 1'b0);
    chk("tp_load_sum", 64'(checksum), 64'h0C0A_0806);
    run_load(13'h0010, 2, 1, 1'b0, -1, 1'b0);
    chk("tp_toggle_sum", 64'(checksum), 64'h0C0A_0806);

    for (int k = 0; k < 4; k++) begin
      src.delete();
      for (int i = 0; i < 24; i++) src.push_back(8'($urandom_range(0, 255)));
      run_load((k == 0) ? 13'h1FFE : 13'($urandom), $urandom_range(1, 6), 2,
               VFY ? 1'b0 : 1'($urandom_range(0, 1)), -1, k == 1);
    end

    src.delete();
    for (int i = 0; i < 16; i++) src.push_back(8'($urandom_range(0, 255)));
    run_load(13'h0200, 4, 0, 1'b0, 10, 1'b0);
    run_load(13'h0300, 3, 2, 1'b0, -1, 1'b0);

    run_zero(1'b0);
    run_zero(1'b1);

`ifdef ORCA_LOADER_VERIFY_EN
    mem[13'h1FFF] = 32'h0000_0001;
    mem[13'h0000] = 32'h0000_0002;
    mem[13'h0001] = 32'hFFFF_FFFF;
    run_verify(13'h1FFF, 3);
    chk("tp_verify_sum", 64'(checksum), 64'h0000_0002);
    for (int k = 0; k < 3; k++) run_verify(13'($urandom), $urandom_range(1, 12));
`else
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(8'($urandom_range(0, 255)));
    run_load(13'h0400, 2, 0, 1'b1, -1, 1'b0);
`endif

    run_reset_mid(VFY);
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(8'($urandom_range(0, 255)));
    run_load(13'h0500, 2, 0, 1'b0, -1, 1'b0);

    chk("sready_in_write", 64'(sr_viol), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lms_orca_oc_mem_loader.md
Name: lms_orca_oc_mem_loader

Overview:
- Avalon-MM master that drives the 8192x32 on-chip memory slave port (13-bit word address, 4-bit byteenable, fixed 1-cycle read latency, no waitrequest).
- LOAD mode: packs an 8-bit boot/firmware byte stream into 32-bit words and writes them from a base address.
- VERIFY mode: reads a word range back and returns a 32-bit additive checksum.
- Sits between the host byte link (SPI/FIFO) and the ORCA instruction/data memory.

Parameters:
- ADDR_W, 13, memory word address width; address wraps modulo 2^ADDR_W.
- LEN_W, 14, width of word-count field; max count 2^(LEN_W-1) = 8192.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_start  in  1  1-cycle pulse; accepted only in IDLE
- cmd_mode  in  1  0 = LOAD, 1 = VERIFY
- cmd_addr  in  ADDR_W  start word address
- cmd_words  in  LEN_W  number of words; 0 is legal
- cmd_abort  in  1  cancel current command
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  stream byte accepted when s_valid & s_ready
- avm_address  out  ADDR_W  memory word address
- avm_chipselect  out  1  memory select
- avm_write  out  1  write strobe
- avm_byteenable  out  4  byte lanes
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data, valid 1 cycle after the read cycle
- busy  out  1  command in progress
- done  out  1  1-cycle completion pulse
- checksum  out  32  sum mod 2^32 of all words written or read by the last command

Behaviour:
- Reset: all outputs 0; state IDLE. checksum holds its value until the next accepted cmd_start, which clears it to 0.
- Interface decision: single clock clk; reset_n is asynchronous, active-low.
- States: IDLE, COLLECT, WRITE, RD_ISSUE, RD_DRAIN, FINISH.
- IDLE
  - cmd_start latches addr/count, clears checksum, sets busy the next cycle.
  - If count = 0, goes to FINISH; else mode 0 -> COLLECT, mode 1 -> RD_ISSUE.
  - cmd_start is ignored while busy.
- COLLECT
  - s_ready = 1.
  - Each accepted byte shifts in little-endian: 1st byte -> writedata[7:0], 4th -> [31:24].
  - After the 4th byte, goes to WRITE; s_ready = 0 in WRITE.
- WRITE
  - One cycle: chipselect = write = 1, byteenable = 4'hF, address = current pointer.
  - checksum += word; pointer += 1 (wraps 8191 -> 0); remaining -= 1.
  - Goes to FINISH if remaining becomes 0, else COLLECT.
  - Sustained rate: 1 word per 5 cycles.
- RD_ISSUE
  - chipselect = 1, write = 0, byteenable = 4'hF, one read per cycle back-to-back, pointer increments with wrap.
  - After the last read is issued, goes to RD_DRAIN.
- Read data
  - avm_readdata is captured exactly 1 cycle after each read cycle and added to checksum.
  - RD_DRAIN is one cycle that accumulates the final word, then goes to FINISH.
  - N words take N+1 cycles.
- FINISH
  - done = 1 for one cycle, busy = 0, checksum is final.
  - Returns to IDLE.
- Abort: cmd_abort in any busy state
  - Next cycle: IDLE, busy = 0, no done, partial word discarded, no further bus cycles.
  - A read already issued is not accumulated.
- Simultaneous events:
  - cmd_abort and cmd_start in IDLE: the abort wins, no command starts.
  - cmd_abort in the same cycle as WRITE: that write still completes.
- Reset mid-operation: immediate return to IDLE; a pending bus strobe drops asynchronously.
- Bus: avm_* are registered outputs; chipselect is 0 in all cycles other than WRITE/RD_ISSUE.

Optional Feature:
- Macro: ORCA_LOADER_VERIFY_EN.
- Defined: VERIFY mode as above.
- Undefined:
  - RD_ISSUE/RD_DRAIN are not built.
  - cmd_mode is ignored and every command is LOAD.
  - avm_readdata is unused; checksum still sums the written words.

Test Plan:
- Load 2 words at addr 0x0010:
  - bytes 01 02 03 04 05 06 07 08 -> writes 0x04030201 @0x0010 and 0x08070605 @0x0011, byteenable F.
  - done after the 2nd write; checksum 0x0C0A0806.
- Verify 3 words at 0x1FFF with memory model 0x1FFF = 1, 0x0000 = 2, 0x0001 = 0xFFFFFFFF:
  - addresses issued 0x1FFF, 0x0000, 0x0001 in consecutive cycles.
  - done 4 cycles after the first read; checksum 0x00000002.
- cmd_words = 0 in either mode -> no chipselect; done 2 cycles after cmd_start; checksum 0.
- Load with s_valid toggling every other cycle -> identical writes and checksum to the gapless case; s_ready = 0 during WRITE.
- Abort after 2 bytes of the 3rd word of a 4-word load:
  - exactly 2 writes occur; busy falls next cycle; no done.
  - a following cmd_start runs normally.
- reset_n asserted during RD_ISSUE -> all outputs 0 without waiting for a clk edge; cmd_start while busy has no effect.
